matvec_loader: RTL and testbench

MATVEC_LOADER -- requirements
Module: matvec_loader

---
 rtl/matvec_loader.sv | 113 +++++++++++
 tb/tb_matvec_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_loader.sv
// Streams DEPTH*DEPTH matrix elements (row-major) followed by DEPTH vector
// elements into operand registers, then holds them for a downstream multiplier.
module matvec_loader #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] a_matrix [DEPTH][DEPTH],
  output logic [DATA_WIDTH-1:0] b_vector [DEPTH],
  output logic                  mult_valid,
  input  logic                  mult_done,
  output logic                  busy
);

  localparam int NUM_A  = DEPTH * DEPTH;
  localparam int NUM_EL = NUM_A + DEPTH;
  localparam int CNT_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_EL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer;
  logic             last_el;

  assign xfer    = (state_q == LOAD) && s_valid;
  assign last_el = (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          // The counter parks on the last index so it can never wrap.
          if (last_el) state_d = HOLD;
          else         cnt_d   = cnt_q + CNT_W'(1);
        end
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (mult_done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign s_ready    = (state_q == LOAD);
  assign mult_valid = (state_q == HOLD);
  assign busy       = (state_q != IDLE);

  // Each operand element owns a register with a decoded write enable; the
  // write happens on any LOAD transfer, including one coinciding with abort.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
      localparam logic [CNT_W-1:0] A_IDX = CNT_W'(gi * DEPTH + gj);
      logic [DATA_WIDTH-1:0] a_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         a_q <= '0;
        else if (xfer && (cnt_q == A_IDX)) a_q <= s_data;
      end

      assign a_matrix[gi][gj] = a_q;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vec
    localparam logic [CNT_W-1:0] B_IDX = CNT_W'(NUM_A + gi);
    logic [DATA_WIDTH-1:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         b_q <= '0;
      else if (xfer && (cnt_q == B_IDX)) b_q <= s_data;
    end

    assign b_vector[gi] = b_q;
  end

endmodule

// File: tb/tb_matvec_loader.sv
// Self-checking bench for matvec_loader: table vectors, directed corner
// sequences and random traffic against a behavioural operand-set model.
module tb_matvec_loader;

  localparam int D  = 8;
  localparam int NA = D * D;
  localparam int NE = NA + D;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] a_matrix [D][D];
  logic [7:0] b_vector [D];
  logic       mult_valid;
  logic       mult_done;
  logic       busy;

  matvec_loader #(.DEPTH(D), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .a_matrix  (a_matrix),
    .b_vector  (b_vector),
    .mult_valid(mult_valid),
    .mult_done (mult_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = waiting, 1 = collecting elements, 2 = holding.
  int m_mode;
  int m_n;
  int m_a [D][D];
  int m_b [D];
  int loads_done;

  typedef struct {
    int st; int ab; int sv; int sd; int md;
    int er; int ev; int eb;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_n    = 0;
    for (int i = 0; i < D; i++) begin
      m_b[i] = 0;
      for (int j = 0; j < D; j++) m_a[i][j] = 0;
    end
  endtask

  task automatic chk_all(input string tag);
    int ai, aj, av, ev;
    bit bad;
    chk({tag, " s_ready"},    int'(s_ready),    int'(m_mode == 1));
    chk({tag, " mult_valid"}, int'(mult_valid), int'(m_mode == 2));
    chk({tag, " busy"},       int'(busy),       int'(m_mode != 0));
    bad = 0; ai = 0; aj = 0; av = 0; ev = 0;
    for (int k = 0; k < NE; k++) begin
      int act_v, exp_v;
      if (k < NA) begin
        act_v = int'(a_matrix[k / D][k % D]);
        exp_v = m_a[k / D][k % D];
      end else begin
        act_v = int'(b_vector[k - NA]);
        exp_v = m_b[k - NA];
      end
      if (!bad && act_v != exp_v) begin
        bad = 1; ai = k; av = act_v; ev = exp_v;
      end
    end
    chk($sformatf("%s operand element %0d", tag, ai), av, ev);
  endtask

  // One clock: apply inputs, advance the model by the same rules, compare.
  task automatic cyc(input int st, input int ab, input int sv, input int sd, input int md,
                     input string tag);
    int nxt;
    start     = st[0];
    abort     = ab[0];
    s_valid   = sv[0];
    s_data    = sd[7:0];
    mult_done = md[0];
    nxt = m_mode;
    case (m_mode)
      0: if (st[0]) begin nxt = 1; m_n = 0; end
      1: begin
        if (sv[0]) begin
          if (m_n < NA) m_a[m_n / D][m_n % D] = sd & 255;
          else          m_b[m_n - NA]         = sd & 255;
          if (m_n == NE - 1) nxt = 2;
          else               m_n++;
        end
        if (ab[0]) begin nxt = 0; m_n = 0; end
      end
      default: if (md[0]) nxt = 0;
    endcase
    @(posedge clk);
    if (nxt == 2 && m_mode != 2) begin
      loads_done++;
      $display("load %0d complete at %0t: a00=%0d b7=%0d", loads_done, $time, m_a[0][0], m_b[D-1]);
    end
    m_mode = nxt;
    #1;
    chk_all(tag);
  endtask

  initial begin
    int n, v;
    loads_done = 0;
    tbl[0] = '{st:1, ab:0, sv:0, sd:0,   md:0, er:1, ev:0, eb:1};
    tbl[1] = '{st:0, ab:0, sv:0, sd:77,  md:0, er:1, ev:0, eb:1};
    tbl[2] = '{st:1, ab:0, sv:1, sd:5,   md:0, er:1, ev:0, eb:1};
    tbl[3] = '{st:0, ab:0, sv:0, sd:0,   md:1, er:1, ev:0, eb:1};
    tbl[4] = '{st:0, ab:1, sv:1, sd:9,   md:0, er:0, ev:0, eb:0};
    tbl[5] = '{st:0, ab:1, sv:1, sd:3,   md:0, er:0, ev:0, eb:0};
    tbl[6] = '{st:0, ab:0, sv:1, sd:4,   md:1, er:0, ev:0, eb:0};
    tbl[7] = '{st:1, ab:0, sv:1, sd:6,   md:0, er:1, ev:0, eb:1};

    rst_n = 1'b0; start = 0; abort = 0; s_valid = 0; s_data = 0; mult_done = 0;
    model_reset();
    #3;
    chk_all("reset");
    #9 rst_n = 1'b1;

    // Row 0 puts start on the very first edge after reset release.
    for (int r = 0; r < 8; r++) begin
      cyc(tbl[r].st, tbl[r].ab, tbl[r].sv, tbl[r].sd, tbl[r].md, $sformatf("table%0d", r));
      chk($sformatf("table%0d ready", r), int'(s_ready), tbl[r].er);
      chk($sformatf("table%0d valid", r), int'(mult_valid), tbl[r].ev);
      chk($sformatf("table%0d busy", r), int'(busy), tbl[r].eb);
    end
    chk("table a00", int'(a_matrix[0][0]), 5);
    chk("table a01 abort-edge write", int'(a_matrix[0][1]), 9);
    cyc(0, 1, 0, 0, 0, "table exit");

    // Full load without stalls.
    cyc(1, 0, 0, 0, 0, "full start");
    for (n = 0; n < NE; n++) begin
      cyc(0, 0, 1, n + 1, 0, "full");
      if (n == NE - 2) chk("full valid before last", int'(mult_valid), 0);
    end
    chk("full valid after last", int'(mult_valid), 1);
    chk("full a00", int'(a_matrix[0][0]), 1);
    chk("full a07", int'(a_matrix[0][7]), 8);
    chk("full a77", int'(a_matrix[7][7]), 64);
    chk("full b0", int'(b_vector[0]), 65);
    chk("full b7", int'(b_vector[7]), 72);

    // Hold with noisy upstream, then release.
    for (int k = 0; k < 10; k++) begin
      cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 255)), 0, "hold");
      chk("hold s_ready", int'(s_ready), 0);
    end
    chk("hold a33", int'(a_matrix[3][3]), 28);
    cyc(0, 0, 0, 0, 1, "release");
    chk("release valid", int'(mult_valid), 0);
    chk("release busy", int'(busy), 0);

    // Stalled stream after corrupting contents with a different load.
    cyc(1, 0, 0, 0, 0, "prep start");
    for (n = 0; n < NE; n++) cyc(0, 0, 1, 200 - n, 0, "prep");
    cyc(0, 0, 0, 0, 1, "prep release");
    cyc(1, 0, 0, 0, 0, "stall start");
    n = 0;
    for (int k = 0; n < NE && k < 400; k++) begin
      if (k % 3 == 0) begin cyc(0, 0, 1, n + 1, 0, "stall"); n++; end
      else                  cyc(0, 0, 0, 8'hEE, 0, "stall gap");
    end
    chk("stall a00", int'(a_matrix[0][0]), 1);
    chk("stall a77", int'(a_matrix[7][7]), 64);
    chk("stall b7", int'(b_vector[7]), 72);
    cyc(0, 0, 0, 0, 1, "one-cycle hold");
    chk("one-cycle hold busy", int'(busy), 0);

    // Abort coinciding with the final element.
    cyc(1, 0, 0, 0, 0, "abfin start");
    for (n = 0; n < NE; n++) cyc(0, int'(n == NE - 1), 1, (n * 3 + 7) & 255, 0, "abfin");
    chk("abfin b7", int'(b_vector[7]), ((NE - 1) * 3 + 7) & 255);
    chk("abfin valid", int'(mult_valid), 0);
    chk("abfin busy", int'(busy), 0);
    cyc(0, 0, 0, 0, 1, "abfin idle");
    chk("abfin idle valid", int'(mult_valid), 0);

    // Abort after 20 transfers, then reload from element 0.
    cyc(1, 0, 0, 0, 0, "ab20 start");
    for (n = 0; n < 20; n++) cyc(0, 0, 1, n + 1, 0, "ab20");
    cyc(0, 1, 0, 0, 0, "ab20 abort");
    chk("ab20 busy", int'(busy), 0);
    chk("ab20 a23", int'(a_matrix[2][3]), 20);
    chk("ab20 a24 old", int'(a_matrix[2][4]), (20 * 3 + 7) & 255);
    cyc(1, 0, 0, 0, 0, "reload start");
    cyc(0, 0, 1, 8'hAA, 0, "reload");
    chk("reload a00", int'(a_matrix[0][0]), 8'hAA);
    chk("reload a01 kept", int'(a_matrix[0][1]), 2);
    cyc(0, 1, 0, 0, 0, "reload abort");

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cyc(int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 199) == 0),
          int'($urandom_range(0, 2) != 0), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 3) == 0), "random");
    end
    cyc(0, 1, 0, 0, 1, "random exit");

    // Reset while holding.
    cyc(1, 0, 0, 0, 0, "rst start");
    for (n = 0; n < NE; n++) begin
      v = int'($urandom_range(1, 255));
      cyc(0, 0, 1, v, 0, "rst load");
    end
    cyc(0, 0, 0, 0, 0, "rst hold");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async reset");
    #2 rst_n = 1'b1;
    cyc(0, 0, 1, 0, 1, "post-reset idle");
    cyc(1, 0, 0, 0, 0, "post-reset start");
    chk("post-reset busy", int'(busy), 1);
    cyc(0, 0, 1, 42, 0, "post-reset xfer");
    chk("post-reset a00", int'(a_matrix[0][0]), 42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
